// File: rtl/rv_multicycle_sequencer_if.sv
// Memory request/acknowledge bus between the sequencer (master) and a memory (slave).
// A request holds all master fields stable until the cycle the slave acknowledges it.
interface rv_multicycle_sequencer_if #(
  parameter int WORD_SIZE = 32
);
  logic                 mem_req;
  logic                 mem_we;
  logic [1:0]           mem_size;
  logic [WORD_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic                 mem_ack;
  logic                 mem_err;
  logic [WORD_SIZE-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_size, mem_addr, mem_wdata,
    input  mem_ack, mem_err, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_size, mem_addr, mem_wdata,
    output mem_ack, mem_err, mem_rdata
  );
endinterface

// File: rtl/rv_multicycle_sequencer.sv
// Multicycle instruction sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK control with
// breakpoint/single-step pausing, MMIO store bypass, memory wait timeout and sticky HALT/ERROR.
module rv_multicycle_sequencer #(
  parameter int                   WORD_SIZE = 32,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = 'h0,
  parameter logic [WORD_SIZE-1:0] MMIO_BASE = 'h0002_0000,
  parameter int                   TIMEOUT   = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  rv_multicycle_sequencer_if.master mem,
  input  logic                      start,
  input  logic                      step_mode,
  input  logic                      step,
  input  logic                      bp_en,
  input  logic [WORD_SIZE-1:0]      bp_addr,
  output logic                      mmio_we,
  output logic [WORD_SIZE-1:0]      mmio_addr,
  output logic [WORD_SIZE-1:0]      mmio_wdata,
  input  logic                      decode_error,
  input  logic                      is_load,
  input  logic                      is_store,
  input  logic [1:0]                ls_size,
  input  logic [WORD_SIZE-1:0]      ls_addr,
  input  logic [WORD_SIZE-1:0]      store_data,
  input  logic [WORD_SIZE-1:0]      next_pc,
  output logic [WORD_SIZE-1:0]      instr,
  output logic                      operand_latch,
  output logic                      reg_we,
  output logic [WORD_SIZE-1:0]      load_data,
  output logic [WORD_SIZE-1:0]      pc,
  output logic [3:0]                state,
  output logic [WORD_SIZE-1:0]      retired,
  output logic                      halted,
  output logic                      error,
  output logic [1:0]                error_code
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_EXECUTE   = 4'd3,
    S_MEM       = 4'd4,
    S_WRITEBACK = 4'd5,
    S_PAUSE     = 4'd6,
    S_HALT      = 4'd7,
    S_ERROR     = 4'd8
  } state_e;

  state_e               state_q;
  logic [WORD_SIZE-1:0] pc_q;
  logic [WORD_SIZE-1:0] retired_q;
  logic [WORD_SIZE-1:0] instr_q;
  logic [WORD_SIZE-1:0] load_data_q;
  logic [WORD_SIZE-1:0] mem_addr_q;
  logic [WORD_SIZE-1:0] mem_wdata_q;
  logic [1:0]           mem_size_q;
  logic [1:0]           error_code_q;
  logic [7:0]           wait_q;
  logic                 mem_req_q;
  logic                 mem_we_q;
  logic                 operand_latch_q;
  logic                 reg_we_q;
  logic                 halted_q;
  logic                 error_q;
  logic                 bp_skip_q;

  logic                 mmio_store;
  logic                 mem_op;
  logic                 req_timeout;
  logic [WORD_SIZE-1:0] fetch_pc;
  logic                 bp_trap;
  logic                 enter_fetch;
  logic                 fetch_req;

  assign mmio_store  = is_store && (ls_addr >= MMIO_BASE);
  assign mem_op      = is_load || (is_store && !mmio_store);
  assign req_timeout = (int'(wait_q) + 1) >= TIMEOUT;

  // The PC a new fetch will use: WRITEBACK hands over next_pc in the same edge it commits it.
  assign fetch_pc = (state_q == S_WRITEBACK) ? next_pc : pc_q;
  assign bp_trap  = bp_en && !bp_skip_q && (fetch_pc == bp_addr);

  always_comb begin
    enter_fetch = 1'b0;
    fetch_req   = 1'b0;
    case (state_q)
      S_IDLE: begin
        enter_fetch = start;
        fetch_req   = !bp_trap;
      end
      S_WRITEBACK: begin
        enter_fetch = !step_mode;
        fetch_req   = !bp_trap;
      end
      S_PAUSE: begin
        enter_fetch = step;
        fetch_req   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      pc_q            <= RESET_PC;
      retired_q       <= '0;
      instr_q         <= '0;
      load_data_q     <= '0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      mem_size_q      <= 2'b00;
      error_code_q    <= 2'b00;
      wait_q          <= '0;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      operand_latch_q <= 1'b0;
      reg_we_q        <= 1'b0;
      halted_q        <= 1'b0;
      error_q         <= 1'b0;
      bp_skip_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) state_q <= S_FETCH;
        end
        S_FETCH, S_MEM: begin
          if (!mem_req_q) begin
            // Only a breakpoint trap enters FETCH without a request.
            state_q <= S_PAUSE;
          end else if (mem.mem_ack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (mem.mem_err) begin
              state_q      <= S_ERROR;
              error_q      <= 1'b1;
              error_code_q <= 2'b10;
            end else if (state_q == S_FETCH) begin
              instr_q   <= mem.mem_rdata;
              bp_skip_q <= 1'b0;
              state_q   <= S_DECODE;
            end else begin
              if (!mem_we_q) load_data_q <= mem.mem_rdata;
              reg_we_q <= 1'b1;
              state_q  <= S_WRITEBACK;
            end
          end else if (req_timeout) begin
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            state_q      <= S_ERROR;
            error_q      <= 1'b1;
            error_code_q <= 2'b11;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        S_DECODE: begin
          if (instr_q[6:0] == 7'b111_1111) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end else if (decode_error) begin
            state_q      <= S_ERROR;
            error_q      <= 1'b1;
            error_code_q <= 2'b01;
          end else begin
            state_q         <= S_EXECUTE;
            operand_latch_q <= 1'b1;
          end
        end
        S_EXECUTE: begin
          operand_latch_q <= 1'b0;
          if (mem_op) begin
            state_q     <= S_MEM;
            mem_req_q   <= 1'b1;
            mem_we_q    <= is_store;
            mem_size_q  <= ls_size;
            mem_addr_q  <= ls_addr;
            mem_wdata_q <= store_data;
            wait_q      <= '0;
          end else begin
            state_q  <= S_WRITEBACK;
            reg_we_q <= 1'b1;
          end
        end
        S_WRITEBACK: begin
          reg_we_q  <= 1'b0;
          pc_q      <= next_pc;
          retired_q <= retired_q + 1'b1;
          state_q   <= step_mode ? S_PAUSE : S_FETCH;
        end
        S_PAUSE: begin
          if (step) begin
            state_q   <= S_FETCH;
            bp_skip_q <= 1'b1;
          end
        end
        S_HALT, S_ERROR: ;
        default: begin
          state_q      <= S_ERROR;
          error_q      <= 1'b1;
          error_code_q <= 2'b00;
        end
      endcase

      if (enter_fetch) begin
        mem_req_q  <= fetch_req;
        mem_we_q   <= 1'b0;
        mem_size_q <= 2'b11;
        mem_addr_q <= fetch_pc;
        wait_q     <= '0;
      end
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_size  = mem_size_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;

  // MMIO stores have no handshake, so the strobe follows the EXECUTE-cycle operands directly.
  assign mmio_we    = (state_q == S_EXECUTE) && mmio_store;
  assign mmio_addr  = ls_addr;
  assign mmio_wdata = store_data;

  assign instr         = instr_q;
  assign operand_latch = operand_latch_q;
  assign reg_we        = reg_we_q;
  assign load_data     = load_data_q;
  assign pc            = pc_q;
  assign state         = state_q;
  assign retired       = retired_q;
  assign halted        = halted_q;
  assign error         = error_q;
  assign error_code    = error_code_q;

endmodule
